rv32i_dmem_ctrl: RTL and testbench
==================================

# rv32i_dmem_ctrl

Parametrised data-memory controller for the RV32I core: the next generation of the single-cycle data memory, adding a valid/ready request handshake, configurable wait states, RV32I byte/half/word store and load semantics, and error reporting. It sits between the core's load/store datapath and a word-organised RAM. It lets later multi-cycle cores stall on memory instead of relying on zero-latency access.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, at least 4.
- WAIT_CYCLES, 2: extra cycles between request accept and response; 0 to 15.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low bits used for SB/SH
- store_type  in  3  funct3 code: SB=000, SH=001, SW=010
- load_type  in  3  funct3 code: LB=000, LH=001, LW=010, LBU=100, LHU=101
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  load result after extension; 0 for stores and errors
- rsp_err  out  1  request rejected; qualified by rsp_valid

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE: req_ready=1. When req_valid is 1, latch we, addr, wdata and type, then go to WAIT. If WAIT_CYCLES=0, go directly to RESP.
- WAIT: a down-counter is loaded with WAIT_CYCLES-1 on accept. Go to RESP when it reaches 0.
- RESP: rsp_valid=1 for exactly one cycle, then return to IDLE.
- Commit rule: a store writes the RAM on the clock edge that ends RESP, and only if there is no error.
- Read data is taken from the RAM in RESP and is combinationally extended.
- Word index is addr[$clog2(DEPTH_WORDS)+1:2].
- Out of range: any of addr[31:$clog2(DEPTH_WORDS)+2] nonzero gives rsp_err=1, no write, rsp_rdata=0.
- Illegal type code: store 011–111 or load 011/110/111 gives rsp_err=1, no write.
- Byte lanes are little-endian.
  - SB writes lane addr[1:0].
  - SH writes lanes {addr[1],0} and {addr[1],1}.
  - SW writes all four lanes.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- req_valid is ignored in WAIT and RESP, where req_ready=0. Requests are never queued.

## Timing
- Accept in cycle N: rsp_valid in cycle N+1+WAIT_CYCLES. Next accept is possible in cycle N+2+WAIT_CYCLES.
- Throughput is one request per WAIT_CYCLES+2 cycles.
- Reset values:
  - state=IDLE, req_ready=1
  - rsp_valid=0, rsp_rdata=0, rsp_err=0
  - counter=0
- RAM contents are not reset.
- Reset during WAIT or RESP aborts the access, with no write and no response. The first cycle after reset release is IDLE.
- rsp_rdata and rsp_err are held at 0 whenever rsp_valid=0.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: SH/LH/LHU with addr[0]=1, or SW/LW with addr[1:0]≠0, give rsp_err=1, no write, rsp_rdata=0.
- DMEM_MISALIGN_TRAP_EN undefined: misaligned low address bits are silently forced to 0 (halfword: addr[0]; word: addr[1:0]). The access completes normally with rsp_err=0.

## Structure
- Package rv32i_mem_pkg holds:
  - the store_type/load_type enums with the funct3 encodings above
  - the FSM state enum
  - the lane-mask width constant
- Sub-module dmem_ram: DEPTH_WORDS×32 synchronous-write array with 4 byte-write enables and an asynchronous read port.
- Address decode, extension and the FSM stay in rv32i_dmem_ctrl.

## Test plan
- Handshake latency: WAIT_CYCLES=2, SW 0x12345678 to 0x10 accepted at cycle 0 → rsp_valid only at cycle 3, rsp_err=0, req_ready=0 in cycles 1–3.
- Load extension, after that store:
  - LB 0x11 → 0x00000056
  - LH 0x12 → 0x00001234
  - LW 0x10 → 0x12345678
- Sign vs zero extension: SB 0x80 to 0x20 → LB 0x20 = 0xFFFFFF80; LBU 0x20 = 0x00000080. SH 0xBEEF to 0x22 → LHU 0x20 = 0xBEEF0080.
- Errors:
  - Address 4×DEPTH_WORDS → rsp_err=1, memory unchanged.
  - load_type=011 → rsp_err=1.
  - LW 0x12 → rsp_err=1 when DMEM_MISALIGN_TRAP_EN is defined; 0x12345678 with rsp_err=0 when it is undefined.
- Reset mid-access: assert reset in the WAIT cycle of SW 0xDEADBEEF to 0x30 → no rsp_valid, and a later LW 0x30 returns the old value.
- WAIT_CYCLES=0 back-to-back: two loads held on req_valid → accepts at cycles 0 and 2, responses at cycles 1 and 3.

Source files
------------

// File: rtl/rv32i_mem_pkg.sv
// Shared types for the RV32I data-memory path: funct3 access codes, controller FSM states, lane count.
package rv32i_mem_pkg;

   localparam int LANE_W = 4;

   typedef enum logic [2:0] {
      ST_SB = 3'b000,
      ST_SH = 3'b001,
      ST_SW = 3'b010
   } store_type_e;

   typedef enum logic [2:0] {
      LD_LB  = 3'b000,
      LD_LH  = 3'b001,
      LD_LW  = 3'b010,
      LD_LBU = 3'b100,
      LD_LHU = 3'b101
   } load_type_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data RAM: synchronous byte-enabled write, asynchronous read.
// Contents are deliberately not reset.
module dmem_ram
   import rv32i_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   localparam int AW = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [LANE_W-1:0] be,
   input  logic [AW-1:0]     addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < LANE_W; i++) begin
         if (we && be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/rv32i_dmem_ctrl.sv
// RV32I data-memory controller: one request at a time, response WAIT_CYCLES+1 cycles after accept.
// req_ready drops from accept until the response cycle ends; requests are never queued.
// DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses report rsp_err instead of being force-aligned.
module rv32i_dmem_ctrl
   import rv32i_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  store_type,
   input  logic [2:0]  load_type,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_e      state;
   logic [3:0]  cnt;
   logic        lat_we;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [2:0]  lat_type;

   logic [1:0]        size;
   logic [1:0]        off;
   logic              out_of_range;
   logic              illegal;
   logic              err;
   logic [LANE_W-1:0] be;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;
   logic [31:0]       lane_data;
   logic [31:0]       ext_data;
   logic              ram_we;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         cnt       <= 4'd0;
         lat_we    <= 1'b0;
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
         lat_type  <= 3'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  lat_we    <= req_we;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  lat_type  <= req_we ? store_type : load_type;
                  req_ready <= 1'b0;
                  if (WAIT_CYCLES == 0) begin
                     state     <= S_RESP;
                     rsp_valid <= 1'b1;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) begin
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP: begin
               state     <= S_IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= S_IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

   // Loads and stores share the funct3 size encoding in bits [1:0] for every legal code.
   assign size         = lat_type[1:0];
   assign out_of_range = |lat_addr[31:AW+2];
   assign illegal      = lat_we ? (lat_type > 3'b010)
                                : ((lat_type == 3'b011) || (lat_type[2:1] == 2'b11));

`ifdef DMEM_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = ((size == 2'b01) && lat_addr[0]) ||
                       ((size == 2'b10) && (lat_addr[1:0] != 2'b00));
   assign err = out_of_range | illegal | misaligned;
   assign off = lat_addr[1:0];
`else
   assign err = out_of_range | illegal;
   assign off = (size == 2'b10) ? 2'b00 :
                (size == 2'b01) ? {lat_addr[1], 1'b0} : lat_addr[1:0];
`endif

   always_comb begin
      be        = 4'b1111;
      ram_wdata = lat_wdata;
      case (size)
         2'b00: begin
            be        = 4'b0001 << off;
            ram_wdata = {4{lat_wdata[7:0]}};
         end
         2'b01: begin
            be        = 4'b0011 << off;
            ram_wdata = {2{lat_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign ram_we = (state == S_RESP) && lat_we && !err;

   dmem_ram #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .be    (be),
      .addr  (lat_addr[AW+1:2]),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   assign lane_data = ram_rdata >> {off, 3'b000};

   always_comb begin
      ext_data = lane_data;
      case (lat_type)
         LD_LB:   ext_data = {{24{lane_data[7]}}, lane_data[7:0]};
         LD_LH:   ext_data = {{16{lane_data[15]}}, lane_data[15:0]};
         LD_LBU:  ext_data = {24'd0, lane_data[7:0]};
         LD_LHU:  ext_data = {16'd0, lane_data[15:0]};
         default: ext_data = lane_data;
      endcase
   end

   assign rsp_rdata = (rsp_valid && !lat_we && !err) ? ext_data : 32'd0;
   assign rsp_err   = rsp_valid & err;

endmodule

// File: tb/tb_rv32i_dmem_ctrl.sv
// Bench for rv32i_dmem_ctrl: table of requests checked through a response scoreboard,
// plus cycle-exact sequences for latency, reset abort and zero-wait back-to-back.
module tb_rv32i_dmem_ctrl;
   import rv32i_mem_pkg::*;

`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  typ;
      logic [31:0] exp_rdata;
      logic        exp_err;
      string       name;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we, rsp_valid, rsp_err;
   logic [31:0] req_addr, req_wdata, rsp_rdata;
   logic [2:0]  store_type, load_type;

   logic        v0, rdy0, we0, rv0, re0;
   logic [31:0] addr0, wdata0, rd0;
   logic [2:0]  st0, ld0;

   int   n_checks = 0;
   int   n_err    = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   vec_t tbl[$];

   always #5 clk = ~clk;

   rv32i_dmem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .store_type(store_type), .load_type(load_type),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   rv32i_dmem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0),
      .req_we(we0), .req_addr(addr0), .req_wdata(wdata0),
      .store_type(st0), .load_type(ld0),
      .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] typ, input logic [31:0] rd, input logic er,
                               input string name);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.typ = typ;
      v.exp_rdata = rd; v.exp_err = er; v.name = name;
      return v;
   endfunction

   // Scoreboard: every response of the main DUT must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && rsp_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response");
         end else begin
            mon_e = exp_q.pop_front();
            check({mon_e.name, "_rdata"}, rsp_rdata, mon_e.rdata);
            check({mon_e.name, "_err"}, 32'(rsp_err), 32'(mon_e.err));
         end
      end
   end

   task automatic do_req(input vec_t v);
      int i;
      @(negedge clk);
      req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
      store_type = v.typ; load_type = v.typ;
      i = 0;
      while (!req_ready && i < 50) begin
         @(negedge clk);
         i++;
      end
      if (!req_ready) begin
         n_checks++;
         n_err++;
         $display("FAIL %s_accept: req_ready stuck at 0, expected 1", v.name);
         req_valid = 1'b0;
         return;
      end
      exp_q.push_back('{v.exp_rdata, v.exp_err, v.name});
      @(negedge clk);
      req_valid = 1'b0;
      i = 0;
      while (exp_q.size() != 0 && i < 50) begin
         @(negedge clk);
         i++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_err++;
         $display("FAIL %s_rsp_timeout: got no response, expected one", v.name);
         exp_q.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seen;

      // Stimulus table, applied after the handshake store of 0x12345678 to 0x10.
      tbl.push_back(mk(0, 32'h11, 0, LD_LB,  32'h00000056, 0, "lb_0x11"));
      tbl.push_back(mk(0, 32'h12, 0, LD_LH,  32'h00001234, 0, "lh_0x12"));
      tbl.push_back(mk(0, 32'h10, 0, LD_LW,  32'h12345678, 0, "lw_0x10"));
      tbl.push_back(mk(0, 32'h12, 0, LD_LW,  TRAP ? 32'h0 : 32'h12345678, TRAP, "lw_misalign"));
      tbl.push_back(mk(0, 32'h13, 0, LD_LH,  TRAP ? 32'h0 : 32'h00001234, TRAP, "lh_misalign"));
      tbl.push_back(mk(1, 32'h20, 32'h00000000, ST_SW, 0, 0, "sw_clear_0x20"));
      tbl.push_back(mk(1, 32'h20, 32'hAAAAAA80, ST_SB, 0, 0, "sb_0x20"));
      tbl.push_back(mk(0, 32'h20, 0, LD_LB,  32'hFFFFFF80, 0, "lb_sign"));
      tbl.push_back(mk(0, 32'h20, 0, LD_LBU, 32'h00000080, 0, "lbu_zero"));
      tbl.push_back(mk(1, 32'h22, 32'h5555BEEF, ST_SH, 0, 0, "sh_0x22"));
      tbl.push_back(mk(0, 32'h20, 0, LD_LW,  32'hBEEF0080, 0, "lw_0x20"));
      tbl.push_back(mk(0, 32'h22, 0, LD_LH,  32'hFFFFBEEF, 0, "lh_sign"));
      tbl.push_back(mk(0, 32'h22, 0, LD_LHU, 32'h0000BEEF, 0, "lhu_zero"));
      tbl.push_back(mk(1, 32'h23, 32'h00001234, ST_SH, 0, TRAP, "sh_misalign"));
      tbl.push_back(mk(0, 32'h20, 0, LD_LW,  TRAP ? 32'hBEEF0080 : 32'h12340080, 0, "lw_after_sh_mis"));
      tbl.push_back(mk(1, 32'h13, 32'h0000007F, ST_SB, 0, 0, "sb_lane3"));
      tbl.push_back(mk(0, 32'h10, 0, LD_LW,  32'h7F345678, 0, "lw_lane3"));
      tbl.push_back(mk(0, 32'h13, 0, LD_LB,  32'h0000007F, 0, "lb_lane3"));
      tbl.push_back(mk(1, 32'h00, 32'hCAFEF00D, ST_SW, 0, 0, "sw_0x0"));
      tbl.push_back(mk(1, 32'h400, 32'hFFFFFFFF, ST_SW, 0, 1, "sw_oor"));
      tbl.push_back(mk(0, 32'h400, 0, LD_LW, 32'h0, 1, "lw_oor"));
      tbl.push_back(mk(1, 32'h80000000, 32'hFFFFFFFF, ST_SW, 0, 1, "sw_oor_msb"));
      tbl.push_back(mk(0, 32'h00, 0, LD_LW,  32'hCAFEF00D, 0, "lw_0x0_unchanged"));
      tbl.push_back(mk(0, 32'h10, 0, 3'b011, 32'h0, 1, "load_011"));
      tbl.push_back(mk(0, 32'h10, 0, 3'b110, 32'h0, 1, "load_110"));
      tbl.push_back(mk(1, 32'h10, 32'h0, 3'b011, 32'h0, 1, "store_011"));
      tbl.push_back(mk(1, 32'h10, 32'h0, 3'b111, 32'h0, 1, "store_111"));
      tbl.push_back(mk(0, 32'h10, 0, LD_LW,  32'h7F345678, 0, "lw_after_illegal"));
      tbl.push_back(mk(1, 32'h3FC, 32'h0F0F0F0F, ST_SW, 0, 0, "sw_last_word"));
      tbl.push_back(mk(0, 32'h3FC, 0, LD_LW, 32'h0F0F0F0F, 0, "lw_last_word"));
      tbl.push_back(mk(1, 32'h30, 32'h11111111, ST_SW, 0, 0, "sw_0x30"));

      reset = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
      store_type = 3'd0; load_type = 3'd0;
      v0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0; st0 = 3'd0; ld0 = 3'd0;
      repeat (3) @(negedge clk);
      check("reset_req_ready", 32'(req_ready), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_rdata", rsp_rdata, 32'd0);
      check("reset_rsp_err", 32'(rsp_err), 32'd0);
      check("reset_dut0_ready", 32'(rdy0), 32'd1);
      reset = 1'b0;

      // Handshake latency: accept in cycle 0, response only in cycle 3.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h12345678;
      store_type = ST_SW;
      check("hs_ready_c0", 32'(req_ready), 32'd1);
      exp_q.push_back('{32'h0, 1'b0, "hs_sw"});
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) req_valid = 1'b0;
         check($sformatf("hs_rsp_valid_c%0d", k), 32'(rsp_valid), 32'(k == 3));
         check($sformatf("hs_req_ready_c%0d", k), 32'(req_ready), 32'(k >= 4));
      end

      foreach (tbl[i]) do_req(tbl[i]);

      // Reset during WAIT aborts the store; no response must follow.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hDEADBEEF;
      store_type = ST_SW;
      check("abort_accept_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      check("abort_in_wait", 32'(req_ready), 32'd0);
      reset = 1'b1;
      #1;
      check("abort_async_ready", 32'(req_ready), 32'd1);
      check("abort_async_rsp_valid", 32'(rsp_valid), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 0) check("abort_idle_after_release", 32'(req_ready), 32'd1);
         seen += int'(rsp_valid);
      end
      check("abort_no_rsp", 32'(seen), 32'd0);
      do_req(mk(0, 32'h30, 0, LD_LW, 32'h11111111, 0, "lw_0x30_old"));

      // Zero wait states: store, then two loads with req_valid held high.
      @(negedge clk);
      v0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'h0BADF00D; st0 = ST_SW;
      check("w0_ready_store", 32'(rdy0), 32'd1);
      @(negedge clk);
      check("w0_store_rsp", 32'(rv0), 32'd1);
      check("w0_store_err", 32'(re0), 32'd0);
      check("w0_ready_in_resp", 32'(rdy0), 32'd0);
      we0 = 1'b0; addr0 = 32'h40; ld0 = LD_LW;
      @(negedge clk);
      check("w0_accept1_ready", 32'(rdy0), 32'd1);
      check("w0_accept1_no_rsp", 32'(rv0), 32'd0);
      @(negedge clk);
      check("w0_rsp1_valid", 32'(rv0), 32'd1);
      check("w0_rsp1_rdata", rd0, 32'h0BADF00D);
      addr0 = 32'h41; ld0 = LD_LB;
      @(negedge clk);
      check("w0_accept2_ready", 32'(rdy0), 32'd1);
      check("w0_accept2_no_rsp", 32'(rv0), 32'd0);
      @(negedge clk);
      check("w0_rsp2_valid", 32'(rv0), 32'd1);
      check("w0_rsp2_rdata", rd0, 32'hFFFFFFF0);
      v0 = 1'b0;
      @(negedge clk);
      check("w0_idle_rdata_zero", rd0, 32'd0);

      repeat (4) @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
